sprite_rle_loader: RTL and testbench

Writer side of the sprite frame RAM that the sprite renderers read. Accepts a byte stream of run-length-encoded 4-bit palette indices and writes them into a rectangular region of the sprite sheet, one pixel per Clk, on the RAM write port. Software/DMA supplies the stream. The renderers keep the read port. Sheet addressing is identical to the renderers': addr = row*SHEET_W + col.

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/sprite_rle_loader_if.sv | 36 +++
 rtl/sprite_rle_loader_addr_gen.sv | 75 +++++++
 rtl/sprite_rle_loader.sv | 174 +++++++++++++++++
 tb/tb_sprite_rle_loader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite sheet RLE loader.
// Contents:
//   SHEET_W, ADDR_W, PIX_W  sheet geometry and RAM port widths
//   CNT_W, RUN_W            region pixel-count and run-length widths
//   loader_state_e          loader FSM states
//   run_len(), pix_idx()    field extraction from one RLE byte
package sprite_pkg;

    localparam int unsigned SHEET_W = 188;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned PIX_W   = 4;
    // region_w (8b) * region_h (10b) needs 18 bits.
    localparam int unsigned CNT_W   = 18;
    // Run length is 1..16.
    localparam int unsigned RUN_W   = 5;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLoad,
        StWrite,
        StDone
    } loader_state_e;

    // [7:4] holds run length minus one.
    function automatic logic [RUN_W-1:0] run_len(input logic [7:0] b);
        return {1'b0, b[7:4]} + RUN_W'(1);
    endfunction

    function automatic logic [PIX_W-1:0] pix_idx(input logic [7:0] b);
        return b[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sprite_rle_loader_if.sv
// Byte stream and RAM write port of the sprite RLE loader.
// Signals:
//   in_data, in_valid, in_ready  RLE byte stream (valid/ready handshake)
//   wr_en, wr_addr, wr_data      sprite frame RAM write port
// Modports:
//   master  stream source / RAM side (software, DMA, testbench)
//   slave   the loader itself
interface sprite_rle_loader_if;
    import sprite_pkg::*;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/sprite_rle_loader_addr_gen.sv
// Region address walker for the sprite RLE loader.
// Holds the position of the next pixel to be written: row base, column and the
// number of pixels left in the region. The only multiply happens on init;
// afterwards the address moves by +1 or wraps to the next row by +SHEET_W.
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   init                  load start position and pixel count from region_*
//   advance               step past the current pixel
//   region_x/y/w/h        latched region geometry
//   addr                  address of the current pixel (registered)
//   last_pixel            current pixel is the last one of the region
//   next_last             the pixel current after this cycle's update is the last
module rle_region_addr_gen
    import sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              init,
    input  logic              advance,
    input  logic [7:0]        region_x,
    input  logic [9:0]        region_y,
    input  logic [7:0]        region_w,
    input  logic [9:0]        region_h,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel,
    output logic              next_last
);

    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        col_q, col_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;

    always_comb begin
        row_base_d  = row_base_q;
        addr_d      = addr_q;
        col_d       = col_q;
        remaining_d = remaining_q;
        if (init) begin
            row_base_d  = ADDR_W'(region_y) * ADDR_W'(SHEET_W) + ADDR_W'(region_x);
            addr_d      = row_base_d;
            col_d       = '0;
            remaining_d = CNT_W'(region_w) * CNT_W'(region_h);
        end else if (advance) begin
            remaining_d = remaining_q - CNT_W'(1);
            if (col_q == region_w - 8'd1) begin
                col_d      = '0;
                row_base_d = row_base_q + ADDR_W'(SHEET_W);
                addr_d     = row_base_d;
            end else begin
                col_d  = col_q + 8'd1;
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            row_base_q  <= '0;
            addr_q      <= '0;
            col_q       <= '0;
            remaining_q <= '0;
        end else begin
            row_base_q  <= row_base_d;
            addr_q      <= addr_d;
            col_q       <= col_d;
            remaining_q <= remaining_d;
        end
    end

    assign addr       = addr_q;
    assign last_pixel = (remaining_q == CNT_W'(1));
    assign next_last  = (remaining_d == CNT_W'(1));

endmodule

// File: rtl/sprite_rle_loader.sv
// Writer side of the sprite frame RAM. Expands a stream of RLE bytes
// ([7:4] = run length - 1, [3:0] = palette index) into one pixel write per
// clock over a rectangular region of the sheet (addr = row*SHEET_W + col).
// Optional build macro LOADER_SKIP_ZERO_EN: palette index 0 is transparent;
// such pixels advance the address and count but do not assert wr_en.
// Ports:
//   Clk, Reset            clock, asynchronous active-high reset
//   start                 one-cycle pulse in idle; latches region_*, begins load
//   region_x/y/w/h        region origin and size in pixels
//   bus (slave)           RLE byte stream in, RAM write port out
//   busy                  high from the cycle after start through done
//   done                  one-cycle pulse after the last pixel of the region
//   overrun               sticky: a run exceeded the remaining pixels
module sprite_rle_loader
    import sprite_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [7:0]          region_x,
    input  logic [9:0]          region_y,
    input  logic [7:0]          region_w,
    input  logic [9:0]          region_h,
    sprite_rle_loader_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    loader_state_e    state_q, state_d;
    logic [7:0]       x_q, w_q;
    logic [9:0]       y_q, h_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic [PIX_W-1:0] idx_q, idx_d;
    logic             overrun_q, overrun_d;
    logic             in_ready_q, in_ready_d;
    logic             wr_en_q, wr_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             latch_region;
    logic             gen_init;
    logic             gen_advance;
    logic             handshake;
    logic             last_pixel;
    logic             next_last;
    logic [ADDR_W-1:0] gen_addr;

    rle_region_addr_gen u_addr_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .init       (gen_init),
        .advance    (gen_advance),
        .region_x   (x_q),
        .region_y   (y_q),
        .region_w   (w_q),
        .region_h   (h_q),
        .addr       (gen_addr),
        .last_pixel (last_pixel),
        .next_last  (next_last)
    );

    assign handshake = bus.in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        idx_d        = idx_q;
        overrun_d    = overrun_q;
        latch_region = 1'b0;
        gen_init     = 1'b0;
        gen_advance  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StSetup;
                    latch_region = 1'b1;
                    overrun_d    = 1'b0;
                end
            end
            StSetup: begin
                gen_init = 1'b1;
                state_d  = (w_q == 8'd0 || h_q == 10'd0) ? StDone : StLoad;
            end
            StLoad: begin
                if (handshake) begin
                    run_d   = run_len(bus.in_data);
                    idx_d   = pix_idx(bus.in_data);
                    state_d = StWrite;
                end
            end
            StWrite: begin
                gen_advance = 1'b1;
                if (last_pixel) begin
                    // Region full: leftover pixels of the run are dropped.
                    state_d = StDone;
                    if (run_q != RUN_W'(1)) begin
                        overrun_d = 1'b1;
                    end
                end else if (run_q == RUN_W'(1)) begin
                    if (handshake) begin
                        run_d = run_len(bus.in_data);
                        idx_d = pix_idx(bus.in_data);
                    end else begin
                        state_d = StLoad;
                    end
                end else begin
                    run_d = run_q - RUN_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the
    // cycle the FSM is actually in.
    always_comb begin
        in_ready_d = (state_d == StLoad) ||
                     (state_d == StWrite && run_d == RUN_W'(1) && !next_last);
`ifdef LOADER_SKIP_ZERO_EN
        wr_en_d    = (state_d == StWrite) && (idx_d != '0);
`else
        wr_en_d    = (state_d == StWrite);
`endif
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            run_q      <= '0;
            idx_q      <= '0;
            overrun_q  <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (latch_region) begin
                x_q <= region_x;
                y_q <= region_y;
                w_q <= region_w;
                h_q <= region_h;
            end
            run_q      <= run_d;
            idx_q      <= idx_d;
            overrun_q  <= overrun_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = gen_addr;
    assign bus.wr_data  = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sprite_rle_loader.sv
// Scoreboard bench for sprite_rle_loader. The stimulus side feeds RLE bytes and,
// on each accepted byte, expands it into expected (addr, idx) writes using the
// region's row/column arithmetic; a monitor pops and compares every RAM write.
// Honours LOADER_SKIP_ZERO_EN the same way the design does.
module tb_sprite_rle_loader;

    logic       Clk;
    logic       Reset;
    logic       start;
    logic [7:0] region_x;
    logic [9:0] region_y;
    logic [7:0] region_w;
    logic [9:0] region_h;
    logic       busy;
    logic       done;
    logic       overrun;

    sprite_rle_loader_if bus ();

    sprite_rle_loader dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (start),
        .region_x (region_x),
        .region_y (region_y),
        .region_w (region_w),
        .region_h (region_h),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

`ifdef LOADER_SKIP_ZERO_EN
    localparam bit SkipZero = 1'b1;
`else
    localparam bit SkipZero = 1'b0;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t     exp_q[$];
    longint   wr_times[$];
    longint   last_wr_time;
    int       n_checks = 0;
    int       n_fail   = 0;
    int       hs_cnt   = 0;

    // Reference model state for the current load.
    int m_x, m_y, m_w, m_h, m_pos, m_total, m_pushed;
    bit m_overrun, m_last_written;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the oldest expected write.
    always @(negedge Clk) begin
        if (!Reset && bus.wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", longint'(bus.wr_addr), e.addr);
                check("wr_data", longint'(bus.wr_data), e.data);
            end
            wr_times.push_back($time);
            last_wr_time = $time;
        end
    end

    task automatic model_accept(input logic [7:0] b);
        int run;
        int idx;
        run = int'(b[7:4]) + 1;
        idx = int'(b[3:0]);
        hs_cnt++;
        for (int k = 0; k < run; k++) begin
            if (m_pos < m_total) begin
                exp_t e;
                e.addr = ((m_y + m_pos / m_w) * 188 + m_x + m_pos % m_w) % (1 << 19);
                e.data = idx;
                if (!(SkipZero && idx == 0)) begin
                    exp_q.push_back(e);
                    m_pushed++;
                    if (m_pos == m_total - 1) m_last_written = 1'b1;
                end
                m_pos++;
            end else begin
                m_overrun = 1'b1;
            end
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic start_load(input int x, input int y, input int w, input int h);
        region_x = 8'(x);
        region_y = 10'(y);
        region_w = 8'(w);
        region_h = 10'(h);
        start    = 1'b1;
        m_x = x; m_y = y; m_w = w; m_h = h;
        m_pos = 0; m_total = w * h; m_pushed = 0;
        m_overrun = 1'b0; m_last_written = 1'b0;
        wr_times.delete();
        @(negedge Clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("overrun_cleared", overrun, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            // in_ready only changes at posedge, so this value holds at the next edge.
            if (bus.in_ready) begin
                ok = 1'b1;
                model_accept(b);
                break;
            end
            @(negedge Clk);
        end
        if (ok) @(negedge Clk);
        bus.in_valid = 1'b0;
        check("handshake_in_time", ok, 1);
    endtask

    task automatic finish_load(output int waited);
        waited = 0;
        while (!done && waited < 300) begin
            @(negedge Clk);
            waited++;
        end
        check("done_seen", done, 1);
        if (done) begin
            check("overrun", overrun, m_overrun);
            check("busy_in_done", busy, 1);
            if (m_last_written) check("done_latency", $time - last_wr_time, 10);
            @(negedge Clk);
            check("done_pulse", done, 0);
            check("busy_after_done", busy, 0);
            check("sb_drained", exp_q.size(), 0);
            check("write_count", wr_times.size(), m_pushed);
        end
    endtask

    task automatic check_consecutive(input string name);
        for (int i = 1; i < wr_times.size(); i++) begin
            check(name, wr_times[i] - wr_times[i-1], 10);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit     ok;
        int     waited;
        int     hs0;
        longint t0;
        int     n;

        Reset = 1'b1;
        start = 1'b0;
        region_x = '0; region_y = '0; region_w = '0; region_h = '0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        last_wr_time = 0;
        #3;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        #9 Reset = 1'b0;
        @(negedge Clk);

        // Basic run: 2x2 region, one 4-pixel run.
        start_load(43, 114, 2, 2);
        send_byte(8'h31, ok);
        finish_load(waited);
        check_consecutive("basic_no_bubble");

        // Back-to-back bytes, second accepted on the first WRITE cycle.
        start_load(43, 114, 2, 2);
        hs0 = hs_cnt;
        send_byte(8'h05, ok);
        t0 = $time;
        send_byte(8'h27, ok);
        check("b2b_ready_in_write1", $time - t0, 10);
        finish_load(waited);
        check("b2b_handshakes", hs_cnt - hs0, 2);
        check_consecutive("b2b_no_bubble");

        // Overrun, then a fresh start clears it.
        start_load(0, 0, 3, 1);
        send_byte(8'hF2, ok);
        finish_load(waited);
        start_load(200, 1000, 1, 1);
        send_byte(8'h0A, ok);
        finish_load(waited);

        // Stall mid-load; a start during the stall must be ignored.
        start_load(5, 7, 3, 2);
        send_byte(8'h11, ok);
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_wr_en", bus.wr_en, 0);
            check("stall_busy", busy, 1);
            region_x = 8'd99;
            start = (i == 1);
            @(negedge Clk);
        end
        start = 1'b0;
        send_byte(8'h31, ok);
        finish_load(waited);

        // Empty region.
        start_load(10, 10, 0, 4);
        finish_load(waited);
        check("empty_done_quick", waited <= 3, 1);

        // Bytes offered while idle must stall.
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("idle_stall", bus.in_ready, 0);
            @(negedge Clk);
        end
        bus.in_valid = 1'b0;

        // Reset during the third pixel of a run, then a clean reload.
        start_load(10, 20, 4, 3);
        send_byte(8'h71, ok);
        n = 0;
        while (wr_times.size() < 3 && n < 50) begin
            @(negedge Clk);
            #1;
            n++;
        end
        check("reached_3rd_pixel", wr_times.size() >= 3, 1);
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_wr_en", bus.wr_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_wr_addr", bus.wr_addr, 0);
        check("mid_rst_wr_data", bus.wr_data, 0);
        exp_q.delete();
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("post_rst_idle", busy, 0);
        start_load(10, 20, 4, 3);
        send_byte(8'h71, ok);
        send_byte(8'h32, ok);
        finish_load(waited);

        // Transparent pixels (skipped only when LOADER_SKIP_ZERO_EN is defined).
        start_load(30, 40, 3, 1);
        send_byte(8'h10, ok);
        send_byte(8'h03, ok);
        finish_load(waited);

        // Randomized loads.
        for (int t = 0; t < 40; t++) begin
            int w;
            int h;
            w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            h = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
            start_load($urandom_range(0, 255), $urandom_range(0, 1023), w, h);
            while (m_pos < m_total) begin
                repeat ($urandom_range(0, 2)) @(negedge Clk);
                send_byte(8'($urandom), ok);
                if (!ok) break;
            end
            finish_load(waited);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
